// File: rtl/rgb_pkg.sv
// rgb_pkg: shared types and constants for the RGB pixel feeder.
package rgb_pkg;
  typedef enum logic [1:0] {SYNC, FILL, RUN, UNDER} state_t;
  typedef struct packed {
    logic        sof;
    logic [23:0] data;
  } pix_t;
  localparam logic [23:0] BLANK_RGB_DEF = 24'h000000;
endpackage

// File: rtl/rgb_sync_fifo.sv
// rgb_sync_fifo: single-clock FIFO with one-cycle flush, level output and combinational head read.
module rgb_sync_fifo #(
  parameter int W     = 25,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr, rd;
  assign full    = level == LW'(DEPTH);
  assign empty   = level == '0;
  assign wr      = wr_en && !full && !flush;
  assign rd      = rd_en && !empty && !flush;
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr);
      rd_ptr <= rd_ptr + AW'(rd);
      level  <= level + LW'(wr) - LW'(rd);
    end
  end
endmodule

// File: rtl/rgb_pixel_feeder.sv
// rgb_pixel_feeder: buffers a sof-marked pixel stream and releases it frame-aligned on LCD display enable.
module rgb_pixel_feeder
  import rgb_pkg::*;
#(
  parameter int               DATA_W    = 24,
  parameter int               DEPTH     = 512,
  parameter int               PREFILL   = 256,
  parameter logic [DATA_W-1:0] BLANK_RGB = DATA_W'(BLANK_RGB_DEF),
  parameter int               LW        = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_pix_data,
  input  logic              i_pix_sof,
  input  logic              i_pix_valid,
  output logic              o_pix_ready,
  input  logic              i_lcd_vs,
  input  logic              i_lcd_de,
  output logic [DATA_W-1:0] o_rgb,
  output logic              o_underrun,
  output logic [LW-1:0]     o_level
);
  state_t          state;
  logic            vs_q, vs_rise, full, empty, bad_head, flush, wr_en, rd_en;
  logic [DATA_W:0] head;
  assign vs_rise     = i_lcd_vs && !vs_q;
  assign o_pix_ready = state == SYNC ? 1'b1 : !full;
  assign wr_en       = i_pix_valid && o_pix_ready && (state != SYNC || i_pix_sof);
  // The frame check looks at the head before any pop in the same cycle.
  assign bad_head    = empty || !head[DATA_W];
  assign flush       = vs_rise && ((state == RUN && bad_head) || state == UNDER);
  assign rd_en       = state == RUN && i_lcd_de && !empty && !flush;
  rgb_sync_fifo #(.W(DATA_W + 1), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (i_rst),
    .flush   (flush),
    .wr_en   (wr_en),
    .wr_data ({i_pix_sof, i_pix_data}),
    .rd_en   (rd_en),
    .rd_data (head),
    .level   (o_level),
    .full    (full),
    .empty   (empty)
  );
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state      <= SYNC;
      vs_q       <= 1'b0;
      o_rgb      <= BLANK_RGB;
      o_underrun <= 1'b0;
    end else begin
      vs_q       <= i_lcd_vs;
      o_rgb      <= rd_en ? head[DATA_W-1:0] : BLANK_RGB;
      o_underrun <= state == RUN && !flush && i_lcd_de && empty;
      case (state)
        SYNC:  if (i_pix_valid && i_pix_sof) state <= FILL;
        FILL:  if (vs_rise && o_level >= LW'(PREFILL)) state <= RUN;
        RUN:   state <= flush ? SYNC : (i_lcd_de && empty) ? UNDER : RUN;
        UNDER: if (flush) state <= SYNC;
        default: state <= SYNC;
      endcase
    end
  end
endmodule
